// File: rtl/tlb_maint_ctrl.sv
// Maintenance/write-side controller for the shared TLB array: single-entry
// write and read, invalidate-all, and invalidate-by-EPN/TS sweeps.
module tlb_maint_ctrl #(
    parameter int IDX_W   = 4,
    parameter int ENTRY_W = 56
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [IDX_W-1:0]   cmd_index,
    input  logic [ENTRY_W-1:0] cmd_entry,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ENTRY_W-1:0] rsp_entry,
    output logic [IDX_W:0]     rsp_count,
    output logic               tlb_we,
    output logic [IDX_W-1:0]   tlb_waddr,
    output logic [ENTRY_W-1:0] tlb_wdata,
    output logic [IDX_W-1:0]   tlb_raddr,
    input  logic [ENTRY_W-1:0] tlb_rdata,
    output logic               busy
);

    localparam int NUM_ENTRIES = 2 ** IDX_W;
    localparam int V_BIT       = ENTRY_W - 1;
    localparam int TS_BIT      = ENTRY_W - 2;
    localparam int EPN_MSB     = ENTRY_W - 11;
    localparam int EPN_LSB     = ENTRY_W - 30;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [IDX_W:0]   FULL_CNT = (IDX_W + 1)'(NUM_ENTRIES);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT,
        INV_ALL,
        INV_RD,
        INV_CHK,
        RSP
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ENTRY_W-1:0]   entry_q, entry_d;
    logic [IDX_W-1:0]     sweep_q, sweep_d;
    logic [IDX_W:0]       match_q, match_d;
    logic [ENTRY_W-1:0]   rsp_entry_q, rsp_entry_d;
    logic [IDX_W:0]       rsp_count_q, rsp_count_d;
    logic [IDX_W-1:0]     waddr_q, waddr_d;
    logic [ENTRY_W-1:0]   wdata_q, wdata_d;
    logic [IDX_W-1:0]     raddr_q, raddr_d;
    logic                 we_c;
    logic                 accept;
    logic                 epn_hit;

    assign cmd_ready = rst_n && (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // TID is deliberately excluded: the sweep invalidates across all address spaces' TIDs.
    assign epn_hit = tlb_rdata[V_BIT]
                  && (tlb_rdata[TS_BIT] == entry_q[TS_BIT])
                  && (tlb_rdata[EPN_MSB:EPN_LSB] == entry_q[EPN_MSB:EPN_LSB]);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        entry_d     = entry_q;
        sweep_d     = sweep_q;
        match_d     = match_q;
        rsp_entry_d = rsp_entry_q;
        rsp_count_d = rsp_count_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        raddr_d     = raddr_q;
        we_c        = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d   = cmd_index;
                    entry_d = cmd_entry;
                    sweep_d = '0;
                    match_d = '0;
                    case (cmd_op)
                        2'b00:   state_d = WR;
                        2'b01:   state_d = RD_REQ;
                        2'b10:   state_d = INV_ALL;
                        default: state_d = INV_RD;
                    endcase
                end
            end
            WR: begin
                we_c        = 1'b1;
                waddr_d     = idx_q;
                wdata_d     = entry_q;
                rsp_entry_d = entry_q;
                rsp_count_d = '0;
                state_d     = RSP;
            end
            RD_REQ: begin
                raddr_d = idx_q;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                rsp_entry_d = tlb_rdata;
                rsp_count_d = '0;
                state_d     = RSP;
            end
            INV_ALL: begin
                we_c    = 1'b1;
                waddr_d = sweep_q;
                wdata_d = '0;
                if (sweep_q == LAST_IDX) begin
                    rsp_entry_d = '0;
                    rsp_count_d = FULL_CNT;
                    state_d     = RSP;
                end else begin
                    sweep_d = sweep_q + IDX_W'(1);
                end
            end
            INV_RD: begin
                raddr_d = sweep_q;
                state_d = INV_CHK;
            end
            INV_CHK: begin
                if (epn_hit) begin
                    we_c           = 1'b1;
                    waddr_d        = sweep_q;
                    wdata_d        = tlb_rdata;
                    wdata_d[V_BIT] = 1'b0;
                    match_d        = match_q + (IDX_W + 1)'(1);
                end
                // Final-index test precedes the increment so the counter never wraps early.
                if (sweep_q == LAST_IDX) begin
                    rsp_entry_d = '0;
                    rsp_count_d = match_d;
                    state_d     = RSP;
                end else begin
                    sweep_d = sweep_q + IDX_W'(1);
                    state_d = INV_RD;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            entry_q     <= '0;
            sweep_q     <= '0;
            match_q     <= '0;
            rsp_entry_q <= '0;
            rsp_count_q <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            raddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            entry_q     <= entry_d;
            sweep_q     <= sweep_d;
            match_q     <= match_d;
            rsp_entry_q <= rsp_entry_d;
            rsp_count_q <= rsp_count_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            raddr_q     <= raddr_d;
        end
    end

    // Write strobe is gated by reset so an aborted sweep stops at once.
    assign tlb_we    = we_c && rst_n;
    assign tlb_waddr = waddr_d;
    assign tlb_wdata = wdata_d;
    assign tlb_raddr = raddr_d;
    assign rsp_valid = (state_q == RSP);
    assign rsp_entry = rsp_entry_q;
    assign rsp_count = rsp_count_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Directed bench for tlb_maint_ctrl with a behavioural synchronous-read TLB array.
module tb_tlb_maint_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_index;
    logic [55:0] cmd_entry;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [55:0] rsp_entry;
    logic [4:0]  rsp_count;
    logic        tlb_we;
    logic [3:0]  tlb_waddr;
    logic [55:0] tlb_wdata;
    logic [3:0]  tlb_raddr;
    logic [55:0] tlb_rdata;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [55:0] mem [16];

    tlb_maint_ctrl #(.IDX_W(4), .ENTRY_W(56)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_index (cmd_index),
        .cmd_entry (cmd_entry),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_entry (rsp_entry),
        .rsp_count (rsp_count),
        .tlb_we    (tlb_we),
        .tlb_waddr (tlb_waddr),
        .tlb_wdata (tlb_wdata),
        .tlb_raddr (tlb_raddr),
        .tlb_rdata (tlb_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tlb_we) mem[tlb_waddr] <= tlb_wdata;
        tlb_rdata <= mem[tlb_raddr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] pat(input int i);
        return {1'b1, 1'b0, 8'(i), 20'h10000 + 20'(i), 6'h3F, 20'h20000 + 20'(i)};
    endfunction

    // Returns in the cycle after acceptance (T+1).
    task automatic issue(input logic [1:0] op, input logic [3:0] idx, input logic [55:0] ent);
        int n;
        n = 0;
        cmd_op = op; cmd_index = idx; cmd_entry = ent; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            tick;
            n++;
        end
        chk("issue_ready", {63'd0, cmd_ready}, 64'd1);
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [3:0] idx, input logic [55:0] ent,
                          output int lat, output logic [55:0] ent_o, output logic [4:0] cnt_o);
        issue(op, idx, ent);
        lat = 1;
        while (!rsp_valid && lat < 80) begin
            tick;
            lat++;
        end
        ent_o = rsp_entry;
        cnt_o = rsp_count;
        tick;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, pulses, ok, busy_cnt, acc, c;
        logic [55:0] got, cap_e;
        logic [4:0]  cnt, cap_c;
        logic [3:0]  wa [4];
        logic [55:0] wd [4];
        logic        stable, we_seen;
        logic [55:0] e_w, a2, a9, a5, a7, a11, a2_clr, a9_clr, w1, w2;

        e_w    = {1'b1, 1'b0, 8'h12, 20'hABCDE, 6'b110011, 20'h12345};
        a2     = {1'b1, 1'b1, 8'h22, 20'h00400, 6'h15, 20'hAAAA2};
        a9     = {1'b1, 1'b1, 8'h99, 20'h00400, 6'h2A, 20'hBBBB9};
        a5     = {1'b1, 1'b0, 8'h55, 20'h00400, 6'h3F, 20'h000C5};
        a7     = {1'b0, 1'b1, 8'h77, 20'h00400, 6'h3F, 20'h000D7};
        a11    = {1'b1, 1'b1, 8'hBB, 20'h00401, 6'h3F, 20'h000EB};
        a2_clr = {1'b0, 1'b1, 8'h22, 20'h00400, 6'h15, 20'hAAAA2};
        a9_clr = {1'b0, 1'b1, 8'h99, 20'h00400, 6'h2A, 20'hBBBB9};
        w1     = {1'b1, 1'b0, 8'h06, 20'h66666, 6'h01, 20'h06060};
        w2     = {1'b1, 1'b1, 8'h08, 20'h88888, 6'h02, 20'h08080};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_index = 4'd0;
        cmd_entry = '0; rsp_ready = 1'b1;
        tick; tick;
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        chk("rst_busy",      {63'd0, busy}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_we",        {63'd0, tlb_we}, 64'd0);
        chk("rst_rsp_entry", {8'd0, rsp_entry}, 64'd0);
        chk("rst_rsp_count", {59'd0, rsp_count}, 64'd0);
        chk("rst_waddr",     {60'd0, tlb_waddr}, 64'd0);
        chk("rst_raddr",     {60'd0, tlb_raddr}, 64'd0);
        chk("rst_wdata",     {8'd0, tlb_wdata}, 64'd0);
        rst_n = 1'b1;
        tick;
        chk("post_rst_ready", {63'd0, cmd_ready}, 64'd1);

        for (int i = 0; i < 16; i++) run_op(2'b00, 4'(i), pat(i), lat, got, cnt);

        // Abort an invalidate-all sweep while index 5 is on the write port.
        issue(2'b10, 4'd0, '0);
        repeat (5) tick;
        chk("abort_at_idx5", {60'd0, tlb_waddr}, 64'd5);
        rst_n = 1'b0;
        tick; tick;
        chk("abort_busy",      {63'd0, busy}, 64'd0);
        chk("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("abort_we",        {63'd0, tlb_we}, 64'd0);
        chk("abort_waddr",     {60'd0, tlb_waddr}, 64'd0);
        chk("abort_ready",     {63'd0, cmd_ready}, 64'd0);
        rst_n = 1'b1;
        tick;
        run_op(2'b01, 4'd0, '0, lat, got, cnt);
        chk("abort_rd0", {8'd0, got}, 64'd0);
        run_op(2'b01, 4'd4, '0, lat, got, cnt);
        chk("abort_rd4", {8'd0, got}, 64'd0);
        run_op(2'b01, 4'd5, '0, lat, got, cnt);
        chk("abort_rd5", {8'd0, got}, {8'd0, pat(5)});
        run_op(2'b01, 4'd15, '0, lat, got, cnt);
        chk("abort_rd15", {8'd0, got}, {8'd0, pat(15)});

        // Single write then read-back.
        issue(2'b00, 4'd3, e_w);
        chk("wr_we_t1",    {63'd0, tlb_we}, 64'd1);
        chk("wr_waddr_t1", {60'd0, tlb_waddr}, 64'd3);
        chk("wr_wdata_t1", {8'd0, tlb_wdata}, {8'd0, e_w});
        chk("wr_rsp_t1",   {63'd0, rsp_valid}, 64'd0);
        tick;
        chk("wr_we_t2",    {63'd0, tlb_we}, 64'd0);
        chk("wr_rsp_t2",   {63'd0, rsp_valid}, 64'd1);
        chk("wr_rsp_entry", {8'd0, rsp_entry}, {8'd0, e_w});
        chk("wr_rsp_count", {59'd0, rsp_count}, 64'd0);
        tick;
        issue(2'b01, 4'd3, '0);
        chk("rd_raddr_t1", {60'd0, tlb_raddr}, 64'd3);
        lat = 1;
        while (!rsp_valid && lat < 80) begin tick; lat++; end
        chk("rd_latency", 64'(lat), 64'd3);
        chk("rd_entry",   {8'd0, rsp_entry}, {8'd0, e_w});
        tick;

        // Invalidate-all over 16 entries.
        issue(2'b10, 4'd0, '0);
        pulses = 0; ok = 0; busy_cnt = 0; cap_c = '0;
        while (busy && busy_cnt < 40) begin
            if (tlb_we) begin
                if (tlb_waddr == 4'(pulses) && tlb_wdata == '0) ok++;
                pulses++;
            end
            if (rsp_valid) cap_c = rsp_count;
            busy_cnt++;
            tick;
        end
        chk("ia_pulses",   64'(pulses), 64'd16);
        chk("ia_in_order", 64'(ok), 64'd16);
        chk("ia_busy_len", 64'(busy_cnt), 64'd17);
        chk("ia_count",    {59'd0, cap_c}, 64'd16);

        // Invalidate-by-EPN with TS match, TS mismatch, V=0 and EPN mismatch entries.
        run_op(2'b00, 4'd2, a2, lat, got, cnt);
        run_op(2'b00, 4'd9, a9, lat, got, cnt);
        run_op(2'b00, 4'd5, a5, lat, got, cnt);
        run_op(2'b00, 4'd7, a7, lat, got, cnt);
        run_op(2'b00, 4'd11, a11, lat, got, cnt);
        issue(2'b11, 4'd0, {1'b0, 1'b1, 8'h00, 20'h00400, 6'h00, 20'h00000});
        pulses = 0; lat = 1;
        while (!rsp_valid && lat < 80) begin
            if (tlb_we) begin
                if (pulses < 4) begin
                    wa[pulses] = tlb_waddr;
                    wd[pulses] = tlb_wdata;
                end
                pulses++;
            end
            tick;
            lat++;
        end
        chk("epn_latency", 64'(lat), 64'd33);
        chk("epn_count",   {59'd0, rsp_count}, 64'd2);
        chk("epn_pulses",  64'(pulses), 64'd2);
        chk("epn_wa0",     {60'd0, wa[0]}, 64'd2);
        chk("epn_wd0",     {8'd0, wd[0]}, {8'd0, a2_clr});
        chk("epn_wa1",     {60'd0, wa[1]}, 64'd9);
        chk("epn_wd1",     {8'd0, wd[1]}, {8'd0, a9_clr});
        tick;
        run_op(2'b01, 4'd5, '0, lat, got, cnt);
        chk("epn_keep5", {8'd0, got}, {8'd0, a5});
        run_op(2'b01, 4'd7, '0, lat, got, cnt);
        chk("epn_keep7", {8'd0, got}, {8'd0, a7});
        run_op(2'b01, 4'd11, '0, lat, got, cnt);
        chk("epn_keep11", {8'd0, got}, {8'd0, a11});

        // Response back-pressure.
        rsp_ready = 1'b0;
        issue(2'b01, 4'd2, '0);
        lat = 1;
        while (!rsp_valid && lat < 80) begin tick; lat++; end
        chk("hold_latency", 64'(lat), 64'd3);
        cap_e = rsp_entry;
        chk("hold_entry", {8'd0, cap_e}, {8'd0, a2_clr});
        stable = 1'b1; we_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cmd_valid = (k == 4); cmd_op = 2'b00; cmd_index = 4'd1; cmd_entry = '1;
            tick;
            if (!(rsp_valid && rsp_entry == cap_e && !cmd_ready)) stable = 1'b0;
            if (tlb_we) we_seen = 1'b1;
        end
        cmd_valid = 1'b0;
        chk("hold_stable", {63'd0, stable}, 64'd1);
        chk("hold_no_we",  {63'd0, we_seen}, 64'd0);
        rsp_ready = 1'b1;
        tick;
        chk("hold_release_ready", {63'd0, cmd_ready}, 64'd1);
        chk("hold_release_valid", {63'd0, rsp_valid}, 64'd0);

        // Back-to-back writes with cmd_valid held high.
        cmd_op = 2'b00; cmd_index = 4'd6; cmd_entry = w1; cmd_valid = 1'b1;
        tick;
        cmd_index = 4'd8; cmd_entry = w2;
        pulses = 0; acc = 0; c = 1;
        repeat (9) begin
            if (tlb_we) begin
                if (pulses < 4) begin
                    wa[pulses] = tlb_waddr;
                    wd[pulses] = tlb_wdata;
                end
                pulses++;
            end
            if (cmd_ready && cmd_valid && acc == 0) acc = c;
            tick;
            if (acc != 0) cmd_valid = 1'b0;
            c++;
        end
        chk("b2b_accept_cycle", 64'(acc), 64'd3);
        chk("b2b_pulses",       64'(pulses), 64'd2);
        chk("b2b_wa0",          {60'd0, wa[0]}, 64'd6);
        chk("b2b_wd0",          {8'd0, wd[0]}, {8'd0, w1});
        chk("b2b_wa1",          {60'd0, wa[1]}, 64'd8);
        chk("b2b_wd1",          {8'd0, wd[1]}, {8'd0, w2});
        run_op(2'b01, 4'd8, '0, lat, got, cnt);
        chk("b2b_rd8", {8'd0, got}, {8'd0, w2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlb_maint_ctrl.md
Name: tlb_maint_ctrl

Overview:
- Maintenance and write-side controller for the shared TLB array; it is the writer for the entries that IMMU/DMMU hit logic reads.
- Executes tlbwe-style single-entry writes, tlbre-style single-entry reads, invalidate-all, and invalidate-by-EPN/TS sweeps, all issued over a valid/ready command channel from the MMU SPR unit.
- Drives the array's single write port and single synchronous read port.
- Asserts busy for the whole of every operation so lookups stall.

Parameters:
- IDX_W, 4, TLB index width; NUM_ENTRIES = 2**IDX_W (default 16).
- ENTRY_W, 56, packed entry width. Fixed; must equal 1+1+8+20+6+20.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when both valid and ready are high
- cmd_op  in  2  00 write, 01 read, 10 invalidate-all, 11 invalidate-by-EPN
- cmd_index  in  IDX_W  target entry for write/read
- cmd_entry  in  ENTRY_W  packed {V, TS, TID[7:0], EPN[19:0], PERMIS[5:0] (SR,UR,SW,UW,SX,UX), RPN[19:0]}, V at MSB
- rsp_valid  out  1  response/completion present
- rsp_ready  in  1  response consumed
- rsp_entry  out  ENTRY_W  read data (read op); written entry (write op); 0 otherwise
- rsp_count  out  IDX_W+1  entries invalidated (ops 10/11); 0 otherwise
- tlb_we  out  1  array write strobe
- tlb_waddr  out  IDX_W  array write index
- tlb_wdata  out  ENTRY_W  array write data
- tlb_raddr  out  IDX_W  array read index; tlb_rdata is valid the cycle after tlb_raddr is driven
- tlb_rdata  in  ENTRY_W  array read data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE; cmd_ready=0 while rst_n is low; rsp_valid, rsp_entry, rsp_count, tlb_we, tlb_waddr, tlb_wdata, tlb_raddr and busy are all 0; the sweep counter and match counter clear.
- Reset mid-operation aborts immediately. Entries already invalidated stay invalid. No response is produced.
- cmd_ready = (state==IDLE) after reset. At most one operation is in flight. A command is captured into internal registers on acceptance.
- States: IDLE, WR, RD_REQ, RD_WAIT, INV_ALL, INV_RD, INV_CHK, RSP.
- Write (op 00), accepted at cycle T:
  - WR at T+1: tlb_we=1, tlb_waddr=index, tlb_wdata=entry for exactly one cycle.
  - RSP from T+2 with rsp_entry=entry.
- Read (op 01), accepted at T:
  - RD_REQ at T+1 drives tlb_raddr=index.
  - RD_WAIT at T+2 registers tlb_rdata into rsp_entry.
  - RSP from T+3.
- Invalidate-all (op 10):
  - INV_ALL writes all-zero entries to indices 0..NUM_ENTRIES-1, one per cycle, T+1..T+NUM_ENTRIES.
  - RSP at T+NUM_ENTRIES+1 with rsp_count=NUM_ENTRIES.
- Invalidate-by-EPN (op 11): per index i = 0..NUM_ENTRIES-1:
  - INV_RD drives tlb_raddr=i.
  - INV_CHK tests tlb_rdata for V=1, EPN equal to cmd EPN, and TS equal to cmd TS. TID is ignored.
  - On a match, tlb_we=1, tlb_waddr=i, tlb_wdata=tlb_rdata with V cleared, and the match counter increments. All other fields are preserved.
  - From INV_CHK at i=NUM_ENTRIES-1 go to RSP. The whole sweep takes 2*NUM_ENTRIES cycles; RSP at T+2*NUM_ENTRIES+1.
- Counters: the sweep counter is IDX_W bits and must not wrap before the final-index check. rsp_count is IDX_W+1 bits so NUM_ENTRIES fits.
- RSP state:
  - rsp_valid=1; rsp_entry and rsp_count held stable until rsp_ready.
  - On the rsp_ready edge: go to IDLE and clear rsp_valid. cmd_ready rises the next cycle; there is no same-cycle accept of the next command.
  - rsp_valid is never asserted outside RSP.
- tlb_we is high only in WR, INV_ALL, or matching INV_CHK cycles. tlb_waddr and tlb_wdata are don't-care (held) when tlb_we=0.
- A write and a read to the same index are never concurrent, since ops are serialised.

Test Plan:
- Reset with rst_n=0 for 2 cycles during an invalidate-all sweep at index 5 -> all outputs 0, busy=0. Entries 0..4 read back invalid, 5..15 are untouched, and no rsp_valid appears.
- Write idx 3 with entry {V=1,TS=0,TID=8'h12,EPN=20'hABCDE,PERMIS=6'b110011,RPN=20'h12345} accepted at T -> tlb_we=1 only at T+1 with waddr=3; rsp_valid at T+2. A following read of idx 3 returns the identical rsp_entry at T'+3.
- Invalidate-all with NUM_ENTRIES=16 -> exactly 16 consecutive tlb_we pulses with waddr 0..15 and wdata=0; rsp_count=16; busy high for 17 cycles.
- Preload idx 2 and 9 with EPN=20'h00400/TS=1, idx 5 with EPN=20'h00400/TS=0, and idx 7 with EPN=20'h00400/V=0. Issue op 11 with EPN 20'h00400, TS=1 -> writes only to idx 2 and 9 with V=0 and other fields unchanged; rsp_count=2; RSP at T+33.
- Hold rsp_ready=0 for 10 cycles after a read completes -> rsp_valid and rsp_entry stay stable, cmd_ready=0, and a cmd_valid pulse is not accepted. Release rsp_ready -> cmd_ready=1 the following cycle.
- Issue back-to-back write commands with cmd_valid held high -> the second command is accepted only at the first cmd_ready after the first response handshake, and each command produces exactly one tlb_we pulse.
